stopwatch_ctrl: RTL and testbench

- Control and timekeeping core of the stop watch. It sits directly downstream of the input synchronizer.
- Consumes the synchronized start/stop and clear enable levels (O_START_EN, O_CLR_EN of the sync stage) and detects their rising edges.
- Runs a RUN/STOP/IDLE state machine and a prescaled BCD time counter MM:SS.cc. Digit outputs feed the display driver.

---
 rtl/stopwatch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: start/clear edge detection, IDLE/RUN/STOP state
// machine, 10 ms prescaler and BCD time chain MM:SS.cc with wrap pulse.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1600,
  parameter int unsigned PRE_W    = 16
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_START_EN,
  input  logic       I_CLR_EN,
  output logic       O_RUN,
  output logic [3:0] O_CSEC_L,
  output logic [3:0] O_CSEC_H,
  output logic [3:0] O_SEC_L,
  output logic [3:0] O_SEC_H,
  output logic [3:0] O_MIN_L,
  output logic [3:0] O_MIN_H,
  output logic       O_OVF
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       csec_l_q, csec_l_d;
  logic [3:0]       csec_h_q, csec_h_d;
  logic [3:0]       sec_l_q, sec_l_d;
  logic [3:0]       sec_h_q, sec_h_d;
  logic [3:0]       min_l_q, min_l_d;
  logic [3:0]       min_h_q, min_h_d;
  logic             start_q, clr_q;
  logic             run_q, run_d;
  logic             ovf_q, ovf_d;
  logic             start_rise, clr_rise, tick;

  // State, counters, edge history and registered outputs
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      csec_l_q <= 4'd0;
      csec_h_q <= 4'd0;
      sec_l_q  <= 4'd0;
      sec_h_q  <= 4'd0;
      min_l_q  <= 4'd0;
      min_h_q  <= 4'd0;
      start_q  <= 1'b0;
      clr_q    <= 1'b0;
      run_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      csec_l_q <= csec_l_d;
      csec_h_q <= csec_h_d;
      sec_l_q  <= sec_l_d;
      sec_h_q  <= sec_h_d;
      min_l_q  <= min_l_d;
      min_h_q  <= min_h_d;
      start_q  <= I_START_EN;
      clr_q    <= I_CLR_EN;
      run_q    <= run_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: transitions, prescaler, BCD carry chain and clear
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    csec_l_d   = csec_l_q;
    csec_h_d   = csec_h_q;
    sec_l_d    = sec_l_q;
    sec_h_d    = sec_h_q;
    min_l_d    = min_l_q;
    min_h_d    = min_h_q;
    ovf_d      = 1'b0;
    tick       = 1'b0;
    start_rise = I_START_EN & ~start_q;
    clr_rise   = I_CLR_EN & ~clr_q;

    case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_RUN;
      ST_RUN:  if (start_rise) state_d = ST_STOP;
      ST_STOP: begin
        // Clear has priority over resume when both rise together
        if (clr_rise)        state_d = ST_IDLE;
        else if (start_rise) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Prescaler advances only while running; tick still lands on a stop edge
    if (state_q == ST_RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (tick) begin
      if (csec_l_q != 4'd9) begin
        csec_l_d = csec_l_q + 4'd1;
      end else begin
        csec_l_d = 4'd0;
        if (csec_h_q != 4'd9) begin
          csec_h_d = csec_h_q + 4'd1;
        end else begin
          csec_h_d = 4'd0;
          if (sec_l_q != 4'd9) begin
            sec_l_d = sec_l_q + 4'd1;
          end else begin
            sec_l_d = 4'd0;
            if (sec_h_q != 4'd5) begin
              sec_h_d = sec_h_q + 4'd1;
            end else begin
              sec_h_d = 4'd0;
              if (min_l_q != 4'd9) begin
                min_l_d = min_l_q + 4'd1;
              end else begin
                min_l_d = 4'd0;
                if (min_h_q != 4'd5) begin
                  min_h_d = min_h_q + 4'd1;
                end else begin
                  min_h_d = 4'd0;
                  ovf_d   = 1'b1;
                end
              end
            end
          end
        end
      end
    end

    // Leaving STOP through clear drops the held time and prescaler phase
    if ((state_q == ST_STOP) && clr_rise) begin
      pre_d    = '0;
      csec_l_d = 4'd0;
      csec_h_d = 4'd0;
      sec_l_d  = 4'd0;
      sec_h_d  = 4'd0;
      min_l_d  = 4'd0;
      min_h_d  = 4'd0;
    end

    run_d = (state_d == ST_RUN);
  end

  assign O_RUN    = run_q;
  assign O_OVF    = ovf_q;
  assign O_CSEC_L = csec_l_q;
  assign O_CSEC_H = csec_h_q;
  assign O_SEC_L  = sec_l_q;
  assign O_SEC_H  = sec_h_q;
  assign O_MIN_L  = min_l_q;
  assign O_MIN_H  = min_h_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a centisecond-count model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic        clk, rst, start, clr;
  logic        run, ovf;
  logic [3:0]  cl, ch, sl, sh, ml, mh;
  logic [23:0] dig;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elapsed time as a plain centisecond count
  int m_total = 0;
  int m_pre   = 0;
  bit m_run = 0, m_paused = 0, m_ovf = 0, m_ps = 0, m_pc = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(16)) dut (
    .I_CLK      (clk),
    .I_RST      (rst),
    .I_START_EN (start),
    .I_CLR_EN   (clr),
    .O_RUN      (run),
    .O_CSEC_L   (cl),
    .O_CSEC_H   (ch),
    .O_SEC_L    (sl),
    .O_SEC_H    (sh),
    .O_MIN_L    (ml),
    .O_MIN_H    (mh),
    .O_OVF      (ovf)
  );

  assign dig = {mh, ml, sh, sl, ch, cl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_digits(input int t);
    return {4'((t / 60000) % 6), 4'((t / 6000) % 10), 4'((t / 1000) % 6),
            4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit rs, rc;
    if (rst) begin
      m_total = 0; m_pre = 0; m_run = 0; m_paused = 0; m_ovf = 0;
      m_ps = 0; m_pc = 0;
    end else begin
      rs = start && !m_ps;
      rc = clr && !m_pc;
      m_ovf = 0;
      if (m_run) begin
        m_pre++;
        if (m_pre == TD) begin
          m_pre = 0;
          m_total++;
          if (m_total == 360000) begin
            m_total = 0;
            m_ovf = 1;
          end
        end
      end
      if (m_run) begin
        if (rs) begin m_run = 0; m_paused = 1; end
      end else if (m_paused) begin
        if (rc) begin m_paused = 0; m_total = 0; m_pre = 0; end
        else if (rs) begin m_run = 1; m_paused = 0; end
      end else if (rs) begin
        m_run = 1;
      end
      m_ps = start;
      m_pc = clr;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("run", 32'(run), 32'(m_run));
    chk_eq("digits", 32'(dig), 32'(exp_digits(m_total)));
    chk_eq("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0; step();
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (m_total != target && n < 20000) begin
      step();
      n++;
    end
    chk_eq("reach_target", 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int ovf_cnt;
    rst = 1'b1; start = 1'b0; clr = 1'b0;
    @(negedge clk);
    repeat (3) step();
    chk_eq("reset_digits", 32'(dig), 32'd0);
    rst = 1'b0;

    // Start: O_RUN on the first high sample, first tick TD edges later
    start = 1'b1; step();
    chk_eq("run_rise", 32'(run), 32'd1);
    step(); start = 1'b0;
    repeat (2) step();
    step();
    chk_eq("first_tick", 32'(dig), 32'h000001);
    repeat (35) step();
    step();
    chk_eq("ten_ticks", 32'(dig), 32'h000010);

    // Stop, freeze, resume
    start = 1'b1; step(); start = 1'b0;
    chk_eq("stopped", 32'(run), 32'd0);
    repeat (50) step();
    pulse_start();
    run_until(327);

    // Clear ignored while running, honoured when stopped
    clr = 1'b1; step(); clr = 1'b0;
    repeat (5) step();
    chk_eq("clr_ignored", 32'(run), 32'd1);
    pulse_start();
    clr = 1'b1; step(); clr = 1'b0;
    chk_eq("cleared", 32'(dig), 32'd0);
    step();
    pulse_start();
    repeat (30) step();

    // Simultaneous start and clear in STOP: clear wins
    pulse_start();
    start = 1'b1; clr = 1'b1; step(); start = 1'b0; clr = 1'b0;
    chk_eq("simul_run", 32'(run), 32'd0);
    chk_eq("simul_dig", 32'(dig), 32'd0);
    step();

    // Wrap: run briefly, stop, preload 59:59.99, resume
    pulse_start();
    repeat (10) step();
    start = 1'b1; step(); start = 1'b0;
    force dut.csec_l_q = 4'd9;
    force dut.csec_h_q = 4'd9;
    force dut.sec_l_q  = 4'd9;
    force dut.sec_h_q  = 4'd5;
    force dut.min_l_q  = 4'd9;
    force dut.min_h_q  = 4'd5;
    m_total = 359999;
    step();
    release dut.csec_l_q;
    release dut.csec_h_q;
    release dut.sec_l_q;
    release dut.sec_h_q;
    release dut.min_l_q;
    release dut.min_h_q;
    step();
    chk_eq("preload", 32'(dig), 32'h595999);
    start = 1'b1; step(); start = 1'b0;
    ovf_cnt = 0;
    repeat (2 * TD + 2) begin
      step();
      ovf_cnt += int'(ovf);
    end
    chk_eq("ovf_once", 32'(ovf_cnt), 32'd1);
    chk_eq("run_after_wrap", 32'(run), 32'd1);

    // Reset mid-count with start held high: one start event on release
    run_until(1234);
    start = 1'b1; rst = 1'b1;
    step();
    chk_eq("rst_run", 32'(run), 32'd0);
    chk_eq("rst_dig", 32'(dig), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_eq("rst_release_run", 32'(run), 32'd1);
    repeat (3) step();
    start = 1'b0;
    repeat (3) step();

    // Random level toggling with occasional reset
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 9) == 0) clr = ~clr;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
